// File: rtl/dac_pkg.sv
// dac_pkg: shared width default, PWM period helper and code type for the DAC transmit path
package dac_pkg;
  localparam int DAC_WIDTH = 8;
  typedef logic [DAC_WIDTH-1:0] code_t;
  function automatic int period(input int w);
    return (1 << w) - 1;
  endfunction
endpackage

// File: rtl/dac_sample_fifo.sv
// dac_sample_fifo: 2-entry synchronous sample FIFO, dout is the head entry
module dac_sample_fifo import dac_pkg::*; #(
  parameter int WIDTH = DAC_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] e1;
  logic do_push, do_pop;
  assign full = count == 2'd2;
  assign empty = count == 2'd0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      dout <= '0;
      e1 <= '0;
      count <= '0;
    end else begin
      dout <= do_pop ? (do_push ? din : e1) : (do_push && empty ? din : dout);
      e1 <= do_push && !do_pop && count == 2'd1 ? din : e1;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
endmodule

// File: rtl/pwm_dac_tx.sv
// pwm_dac_tx: FIFO-buffered code stream replayed as PWM duty and mirrored on the R2R bus
module pwm_dac_tx import dac_pkg::*; #(
  parameter int WIDTH = DAC_WIDTH,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             pwm_out,
  output logic [WIDTH-1:0] R2R_out,
  output logic             period_start,
  output logic             underrun,
  input  logic             clear_underrun
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(period(WIDTH) - 1);
  logic [PW-1:0] presc;
  logic [WIDTH-1:0] cnt, head;
  logic [1:0] count;
  logic running, tick, load, pop, full, empty;
  assign sample_ready = !full;
  assign tick = enable && presc == PLAST;
  assign load = tick && (!running || cnt == LAST);
  assign pop = load && !empty;
  dac_sample_fifo #(.WIDTH(WIDTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(sample_valid),
    .pop(pop),
    .din(sample_in),
    .dout(head),
    .count(count),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      presc <= '0;
      cnt <= '0;
      running <= 1'b0;
      R2R_out <= '0;
      period_start <= 1'b0;
      underrun <= 1'b0;
      pwm_out <= 1'b0;
    end else begin
      presc <= tick || !enable ? '0 : presc + 1'b1;
      running <= enable && (running || tick);
      cnt <= !enable || load ? '0 : tick ? cnt + 1'b1 : cnt;
      R2R_out <= pop ? head : R2R_out;
      period_start <= load;
      underrun <= (load && count == 2'd0) || (underrun && !clear_underrun);
      pwm_out <= running && enable && cnt < R2R_out;
    end
endmodule

// File: tb/tb_pwm_dac_tx.sv
// tb_pwm_dac_tx: directed self-checking bench for pwm_dac_tx
module tb_pwm_dac_tx;
  logic clk = 0, reset = 1, enable = 0, sample_valid = 0, clear_underrun = 0;
  logic [7:0] sample_in = 0;
  logic sample_ready, pwm_out, period_start, underrun;
  logic [7:0] r2r_out;
  logic en4 = 0, v4 = 0;
  logic [7:0] d4 = 0;
  logic ready4, pwm4, ps4, ur4;
  logic [7:0] r2r4;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  pwm_dac_tx #(.WIDTH(8), .PRESCALE(1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sample_in(sample_in),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .pwm_out(pwm_out),
    .R2R_out(r2r_out), .period_start(period_start), .underrun(underrun),
    .clear_underrun(clear_underrun)
  );
  pwm_dac_tx #(.WIDTH(8), .PRESCALE(4)) dut4 (
    .clk(clk), .reset(reset), .enable(en4), .sample_in(d4),
    .sample_valid(v4), .sample_ready(ready4), .pwm_out(pwm4),
    .R2R_out(r2r4), .period_start(ps4), .underrun(ur4),
    .clear_underrun(1'b0)
  );
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic push(input logic [7:0] c);
    sample_in = c;
    sample_valid = 1;
    @(negedge clk);
    sample_valid = 0;
  endtask
  task automatic do_reset;
    enable = 0; en4 = 0; sample_valid = 0; v4 = 0; clear_underrun = 0;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    reset = 1;
  endtask
  task automatic test_reset;
    #2 reset = 0;
    #1;
    total++; if (pwm_out !== 1'b0) begin bad++; $display("FAIL reset_pwm got=%b want=0", pwm_out); end
    total++; if (r2r_out !== 8'h00) begin bad++; $display("FAIL reset_r2r got=%h want=00", r2r_out); end
    total++; if (period_start !== 1'b0) begin bad++; $display("FAIL reset_ps got=%b want=0", period_start); end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun got=%b want=0", underrun); end
    total++; if (sample_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", sample_ready); end
    @(negedge clk);
    reset = 1;
  endtask
  task automatic test_half_duty;
    int hi, ps, first_lo;
    do_reset;
    push(8'h80);
    enable = 1;
    @(negedge clk);
    total++; if (period_start !== 1'b1) begin bad++; $display("FAIL half_first_load got=%b want=1", period_start); end
    total++; if (r2r_out !== 8'h80) begin bad++; $display("FAIL half_r2r got=%h want=80", r2r_out); end
    total++; if (pwm_out !== 1'b0) begin bad++; $display("FAIL half_pwm_lag got=%b want=0", pwm_out); end
    hi = 0; ps = 0; first_lo = 0;
    for (int i = 1; i <= 255; i++) begin
      @(negedge clk);
      hi += int'(pwm_out);
      if (i < 255) ps += int'(period_start);
      if (!pwm_out && first_lo == 0) first_lo = i;
    end
    total++; if (hi != 128) begin bad++; $display("FAIL half_high_clks got=%0d want=128", hi); end
    total++; if (first_lo != 129) begin bad++; $display("FAIL half_first_low got=%0d want=129", first_lo); end
    total++; if (ps != 0) begin bad++; $display("FAIL half_extra_ps got=%0d want=0", ps); end
    total++; if (period_start !== 1'b1) begin bad++; $display("FAIL half_period_255 got=%b want=1", period_start); end
    @(negedge clk);
    total++; if (pwm_out !== 1'b1) begin bad++; $display("FAIL half_second_period got=%b want=1", pwm_out); end
  endtask
  task automatic test_extremes;
    int hi;
    do_reset;
    push(8'h00);
    push(8'hFF);
    enable = 1;
    @(negedge clk);
    total++; if (r2r_out !== 8'h00) begin bad++; $display("FAIL ext_r2r0 got=%h want=00", r2r_out); end
    hi = 0;
    for (int i = 1; i <= 255; i++) begin
      @(negedge clk);
      hi += int'(pwm_out);
    end
    total++; if (hi != 0) begin bad++; $display("FAIL ext_zero_high got=%0d want=0", hi); end
    total++; if (r2r_out !== 8'hFF) begin bad++; $display("FAIL ext_r2rff got=%h want=ff", r2r_out); end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL ext_no_underrun got=%b want=0", underrun); end
    hi = 0;
    for (int i = 1; i <= 255; i++) begin
      @(negedge clk);
      hi += int'(pwm_out);
    end
    total++; if (hi != 255) begin bad++; $display("FAIL ext_full_high got=%0d want=255", hi); end
  endtask
  task automatic test_underrun;
    do_reset;
    push(8'h33);
    enable = 1;
    @(negedge clk);
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL ur_initial got=%b want=0", underrun); end
    wait_n(255);
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL ur_set got=%b want=1", underrun); end
    total++; if (r2r_out !== 8'h33) begin bad++; $display("FAIL ur_r2r_hold got=%h want=33", r2r_out); end
    total++; if (period_start !== 1'b1) begin bad++; $display("FAIL ur_ps got=%b want=1", period_start); end
    clear_underrun = 1;
    @(negedge clk);
    clear_underrun = 0;
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL ur_clear got=%b want=0", underrun); end
    wait_n(253);
    clear_underrun = 1;
    @(negedge clk);
    clear_underrun = 0;
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL ur_set_wins got=%b want=1", underrun); end
    total++; if (period_start !== 1'b1) begin bad++; $display("FAIL ur_ps2 got=%b want=1", period_start); end
  endtask
  task automatic test_back_to_back;
    do_reset;
    sample_in = 8'h21;
    sample_valid = 1;
    @(negedge clk);
    total++; if (sample_ready !== 1'b1) begin bad++; $display("FAIL bb_ready1 got=%b want=1", sample_ready); end
    sample_in = 8'h42;
    @(negedge clk);
    total++; if (sample_ready !== 1'b0) begin bad++; $display("FAIL bb_full got=%b want=0", sample_ready); end
    sample_in = 8'h63;
    wait_n(3);
    total++; if (sample_ready !== 1'b0) begin bad++; $display("FAIL bb_full_hold got=%b want=0", sample_ready); end
    enable = 1;
    @(negedge clk);
    total++; if (r2r_out !== 8'h21) begin bad++; $display("FAIL bb_pop_a got=%h want=21", r2r_out); end
    total++; if (sample_ready !== 1'b1) begin bad++; $display("FAIL bb_ready_after_pop got=%b want=1", sample_ready); end
    @(negedge clk);
    sample_valid = 0;
    total++; if (sample_ready !== 1'b0) begin bad++; $display("FAIL bb_third_accepted got=%b want=0", sample_ready); end
    wait_n(254);
    total++; if (r2r_out !== 8'h42) begin bad++; $display("FAIL bb_pop_b got=%h want=42", r2r_out); end
    wait_n(255);
    total++; if (r2r_out !== 8'h63) begin bad++; $display("FAIL bb_pop_c got=%h want=63", r2r_out); end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL bb_underrun got=%b want=0", underrun); end
  endtask
  task automatic test_enable_drop;
    do_reset;
    push(8'h80);
    push(8'h40);
    enable = 1;
    wait_n(11);
    total++; if (pwm_out !== 1'b1) begin bad++; $display("FAIL en_mid_high got=%b want=1", pwm_out); end
    enable = 0;
    @(negedge clk);
    total++; if (pwm_out !== 1'b0) begin bad++; $display("FAIL en_drop_low got=%b want=0", pwm_out); end
    total++; if (r2r_out !== 8'h80) begin bad++; $display("FAIL en_drop_r2r got=%h want=80", r2r_out); end
    wait_n(4);
    enable = 1;
    @(negedge clk);
    total++; if (period_start !== 1'b1) begin bad++; $display("FAIL en_reload_ps got=%b want=1", period_start); end
    total++; if (r2r_out !== 8'h40) begin bad++; $display("FAIL en_reload_r2r got=%h want=40", r2r_out); end
    wait_n(64);
    total++; if (pwm_out !== 1'b1) begin bad++; $display("FAIL en_last_high got=%b want=1", pwm_out); end
    @(negedge clk);
    total++; if (pwm_out !== 1'b0) begin bad++; $display("FAIL en_first_low got=%b want=0", pwm_out); end
  endtask
  task automatic test_async_reset;
    do_reset;
    push(8'h80);
    push(8'h11);
    enable = 1;
    wait_n(20);
    total++; if (pwm_out !== 1'b1) begin bad++; $display("FAIL ar_pre_high got=%b want=1", pwm_out); end
    #2 reset = 0;
    #1;
    total++; if (pwm_out !== 1'b0) begin bad++; $display("FAIL ar_pwm got=%b want=0", pwm_out); end
    total++; if (r2r_out !== 8'h00) begin bad++; $display("FAIL ar_r2r got=%h want=00", r2r_out); end
    total++; if (sample_ready !== 1'b1) begin bad++; $display("FAIL ar_ready got=%b want=1", sample_ready); end
    @(negedge clk);
    enable = 0;
    reset = 1;
    @(negedge clk);
    enable = 1;
    @(negedge clk);
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL ar_fifo_empty got=%b want=1", underrun); end
    total++; if (r2r_out !== 8'h00) begin bad++; $display("FAIL ar_r2r_hold got=%h want=00", r2r_out); end
  endtask
  task automatic test_prescale;
    int idx, hi, ps;
    do_reset;
    d4 = 8'h40;
    v4 = 1;
    @(negedge clk);
    v4 = 0;
    en4 = 1;
    idx = 0;
    for (int i = 1; i <= 10 && idx == 0; i++) begin
      @(negedge clk);
      if (ps4) idx = i;
    end
    total++; if (idx != 4) begin bad++; $display("FAIL ps4_first_load got=%0d want=4", idx); end
    total++; if (r2r4 !== 8'h40) begin bad++; $display("FAIL ps4_r2r got=%h want=40", r2r4); end
    hi = 0; ps = 0;
    for (int i = 1; i <= 1020; i++) begin
      @(negedge clk);
      hi += int'(pwm4);
      if (i < 1020) ps += int'(ps4);
    end
    total++; if (hi != 256) begin bad++; $display("FAIL ps4_high got=%0d want=256", hi); end
    total++; if (ps != 0) begin bad++; $display("FAIL ps4_extra_ps got=%0d want=0", ps); end
    total++; if (ps4 !== 1'b1) begin bad++; $display("FAIL ps4_period_1020 got=%b want=1", ps4); end
  endtask
  initial begin
    test_reset;
    test_half_duty;
    test_extremes;
    test_underrun;
    test_back_to_back;
    test_enable_drop;
    test_async_reset;
    test_prescale;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
